mem_word_loader: RTL and testbench

//  Write-side counterpart of the core's word-addressed memory read port (addr[14:0] -> out[63:0]).

---
 rtl/core_pkg.sv | 19 +
 rtl/byte_packer.sv | 45 ++++
 rtl/mem_word_loader.sv | 129 ++++++++++++
 tb/tb_mem_word_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and loader state encoding for the core memory path.
// Imported by the word loader and its byte packer.
package core_pkg;

    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 64;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = 16;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: lane register plus byte index.
// word shows the lanes with the incoming byte already merged in.
module byte_packer
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              strobe,
    input  logic [BYTE_W-1:0] data,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] lanes;

    // Merge the strobed byte into its lane so a full word is visible
    // in the same cycle as its last byte.
    always_comb begin
        word = lanes;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (strobe && byte_idx == IDX_W'(i)) begin
                word[i*BYTE_W +: BYTE_W] = data;
            end
        end
    end

    assign word_full = strobe && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    // Lane storage and index; the index wraps to 0 after the last lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            lanes    <= '0;
            byte_idx <= '0;
        end else if (strobe) begin
            lanes    <= word;
            byte_idx <= byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_word_loader.sv
// Byte stream to 64-bit word loader feeding the core memory write port.
// Words go to consecutive addresses from a latched base, wrapping at the top.
module mem_word_loader
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);

    ld_state_t state;
    ld_state_t state_next;

    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] word_next;
    logic              word_full;
    logic              accept;
    logic              start_ok;
    logic              start_nop;
    logic              load_word;
    logic              last_word;
    logic              in_ready_d;
    logic              mem_we_d;
    logic              busy_d;
    logic              done_d;

    assign accept    = in_valid & in_ready;
    assign start_ok  = (state == ST_IDLE) & start & (word_count != '0);
    assign start_nop = (state == ST_IDLE) & start & (word_count == '0);
    assign load_word = accept & word_full;
    assign last_word = (remaining == CNT_W'(1));

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .strobe    (accept),
        .data      (in_data),
        .word      (word_next),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (load_word) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = last_word ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, registered below.
    always_comb begin
        in_ready_d = (state_next == ST_COLLECT);
        mem_we_d   = (state_next == ST_WRITE);
        busy_d     = (state_next == ST_COLLECT) || (state_next == ST_WRITE);
        done_d     = (state_next == ST_DONE) || start_nop;
    end

    // Output registers; address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            in_ready <= in_ready_d;
            mem_we   <= mem_we_d;
            busy     <= busy_d;
            done     <= done_d;
            if (load_word) begin
                mem_addr  <= addr;
                mem_wdata <= word_next;
            end
        end
    end

    // Address and remaining-word counters; the address wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (start_ok) begin
            addr      <= base_addr;
            remaining <= word_count;
        end else if (state == ST_WRITE) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_word_loader.sv
// Directed bench for mem_word_loader with a write scoreboard.
// Expected writes are queued as words are driven and popped on mem_we.
module tb_mem_word_loader;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;

    always #5 clk = ~clk;

    mem_word_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            writes++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] b,
                              input logic [CNT_W-1:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a,
                             input logic [63:0] w, input bit gaps);
        exp_q.push_back('{addr: a, data: w});
        for (int i = 0; i < 8; i++) begin
            send_byte(w[8*i +: 8]);
            if (gaps && i < 7) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        check("we_after_8th", 64'(mem_we), 64'd1);
        check("ready_in_write", 64'(in_ready), 64'd0);
    endtask

    task automatic finish_xfer();
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        check("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b1;
        in_data    = 8'hAA;

        // Reset and idle: nothing accepted.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;

        // Single word at address 0.
        start_xfer(15'd0, 16'd1);
        send_word(15'd0, 64'h0807060504030201, 1'b0);
        finish_xfer();

        // Two words wrapping at the top of memory.
        start_xfer(15'd32767, 16'd2);
        send_word(15'd32767, 64'h0706050403020100, 1'b0);
        send_word(15'd0, 64'h0F0E0D0C0B0A0908, 1'b0);
        finish_xfer();

        // Gapped byte stream.
        start_xfer(15'd100, 16'd1);
        send_word(15'd100, 64'h0807060504030201, 1'b1);
        finish_xfer();

        // Zero-count start is a no-op with a done pulse.
        start      = 1'b1;
        base_addr  = 15'd300;
        word_count = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("nop_done", 64'(done), 64'd1);
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        check("nop_done_clear", 64'(done), 64'd0);

        // Start while busy is ignored.
        start_xfer(15'd200, 16'd2);
        w = 64'h2827262524232221;
        exp_q.push_back('{addr: 15'd200, data: w});
        for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
        start      = 1'b1;
        base_addr  = 15'd512;
        word_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        for (int i = 3; i < 8; i++) send_byte(w[8*i +: 8]);
        check("restart_we", 64'(mem_we), 64'd1);
        send_word(15'd201, 64'h3837363534333231, 1'b0);
        finish_xfer();

        // Reset mid-word aborts the transfer.
        start_xfer(15'd7, 16'd3);
        w = 64'h5857565554535251;
        for (int i = 0; i < 5; i++) send_byte(w[8*i +: 8]);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);

        // Fresh transfer after the abort.
        start_xfer(15'd4095, 16'd1);
        send_word(15'd4095, 64'h1817161514131211, 1'b0);
        finish_xfer();

        repeat (3) @(posedge clk);
        #1;
        check("write_total", 64'(writes), 64'd7);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
